accel_stream_writer: RTL and testbench

//  Write-back DMA (S2MM) for the accelerator result path. Accepts the postproc AXI-Stream from
//  hw_accel and writes it to memory as AXI4 INCR write bursts (AW/W/B) at a programmed address.
//  It is the write-side counterpart of the memory-read/preproc-stream path in core_ctrl.

---
 rtl/accel_core_pkg.sv | 28 ++
 rtl/accel_stream_writer.sv | 194 +++++++++++++++++++
 tb/tb_accel_stream_writer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_core_pkg.sv
// Shared types and constants for the accelerator write-back path.
//  writer_state_e : states of the stream-to-memory writer FSM
//  AXI_BURST_INCR : AxBURST encoding for incrementing bursts
//  AXI_RESP_OKAY  : xRESP encoding for a successful response
//  burst_len()    : beats in the next burst, i.e. min(remaining, max_burst)
package accel_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } writer_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Result fits in 9 bits because max_burst is at most 256.
    function automatic logic [8:0] burst_len(input logic [31:0] remaining,
                                             input logic [31:0] max_burst);
        if (remaining < max_burst) begin
            return 9'(remaining);
        end
        return 9'(max_burst);
    endfunction

endpackage

// File: rtl/accel_stream_writer.sv
// Write-back DMA (S2MM): takes the postproc AXI-Stream and writes it to memory
// as AXI4 INCR bursts, one burst outstanding at a time.
// Ports:
//  clk, rst                    clock, async active-high reset
//  start/base_addr/len_beats   transfer request (pulse) with byte address and beat count
//  busy/done                   transfer in progress / one-cycle completion pulse
//  err/short_pkt               sticky: bad BRESP seen / TLAST before len_beats
//  beats_written               real stream beats accepted in current/last transfer
//  s_t*                        input AXI-Stream slave
//  m_aw*/m_w*/m_b*             AXI4 write-channel master
module accel_stream_writer
    import accel_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [LEN_WIDTH-1:0]      len_beats,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      short_pkt,
    output logic [LEN_WIDTH-1:0]      beats_written,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    // Every burst except the last is full-length, so the address always
    // advances by one full burst.
    localparam int BURST_BYTES = MAX_BURST * STRB_WIDTH;

    writer_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]    beats_q, beats_d;
    logic [8:0]              burst_left_q, burst_left_d;
    logic                    pad_q, pad_d;
    logic                    short_q, short_d;
    logic                    err_q, err_d;
    logic [8:0]              cur_burst;
    logic                    w_fire;

    assign cur_burst = burst_len(32'(remaining_q), 32'(MAX_BURST));
    // Pad beats are always valid so a started burst can always be completed.
    assign w_fire    = (state_q == ST_W) && (pad_q || s_tvalid) && m_wready;

    assign m_awsize      = 3'($clog2(STRB_WIDTH));
    assign m_awburst     = AXI_BURST_INCR;
    assign err           = err_q;
    assign short_pkt     = short_q;
    assign beats_written = beats_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            beats_q      <= '0;
            burst_left_q <= '0;
            pad_q        <= 1'b0;
            short_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            beats_q      <= beats_d;
            burst_left_q <= burst_left_d;
            pad_q        <= pad_d;
            short_q      <= short_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a missing
        // assignment on any path would otherwise infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        beats_d      = beats_q;
        burst_left_d = burst_left_q;
        pad_d        = pad_q;
        short_d      = short_q;
        err_d        = err_q;
        busy         = (state_q != ST_IDLE);
        done         = 1'b0;
        s_tready     = 1'b0;
        m_awvalid    = 1'b0;
        m_awaddr     = '0;
        m_awlen      = '0;
        m_wvalid     = 1'b0;
        m_wdata      = '0;
        m_wstrb      = '0;
        m_wlast      = 1'b0;
        m_bready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = len_beats;
                    beats_d     = '0;
                    pad_d       = 1'b0;
                    short_d     = 1'b0;
                    err_d       = 1'b0;
                    state_d     = (len_beats == '0) ? ST_DONE : ST_AW;
                end
            end

            ST_AW: begin
                m_awvalid = 1'b1;
                m_awaddr  = addr_q;
                m_awlen   = 8'(cur_burst - 9'd1);
                if (m_awready) begin
                    burst_left_d = cur_burst;
                    state_d      = ST_W;
                end
            end

            ST_W: begin
                m_wvalid = pad_q || s_tvalid;
                m_wdata  = pad_q ? '0 : s_tdata;
                m_wstrb  = pad_q ? '0 : '1;
                m_wlast  = (burst_left_q == 9'd1);
                s_tready = m_wready && !pad_q;
                if (w_fire) begin
                    burst_left_d = burst_left_q - 9'd1;
                    if (!pad_q) begin
                        beats_d     = beats_q + LEN_WIDTH'(1);
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                        // TLAST on the final expected beat is normal termination.
                        if (s_tlast && (remaining_q > LEN_WIDTH'(1))) begin
                            short_d = 1'b1;
                            pad_d   = 1'b1;
                        end
                    end
                    if (burst_left_q == 9'd1) begin
                        pad_d   = 1'b0;
                        state_d = ST_B;
                    end
                end
            end

            ST_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    // An error response is recorded but the transfer carries on.
                    if (m_bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if ((remaining_q != '0) && !short_q) begin
                        addr_d  = addr_q + ADDR_WIDTH'(BURST_BYTES);
                        state_d = ST_AW;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_accel_stream_writer.sv
// Directed bench for accel_stream_writer: stream source, AXI write slave
// with optional random stalls, and a word memory model.
module tb_accel_stream_writer;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 16;
    localparam int MAX_BURST  = 16;

    logic                    clk, rst, start;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [LEN_WIDTH-1:0]    len_beats;
    logic                    busy, done, err, short_pkt;
    logic [LEN_WIDTH-1:0]    beats_written;
    logic [DATA_WIDTH-1:0]   s_tdata;
    logic                    s_tvalid, s_tlast, s_tready;
    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [7:0]              m_awlen;
    logic [2:0]              m_awsize;
    logic [1:0]              m_awburst;
    logic                    m_awvalid, m_awready;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [3:0]              m_wstrb;
    logic                    m_wlast, m_wvalid, m_wready;
    logic [1:0]              m_bresp;
    logic                    m_bvalid, m_bready;

    accel_stream_writer #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH(LEN_WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .len_beats(len_beats), .busy(busy), .done(done), .err(err),
        .short_pkt(short_pkt), .beats_written(beats_written),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source / slave configuration and observation state.
    logic [31:0] src_data [0:127];
    int          src_len, src_idx, tlast_at;
    int          stall_pct, err_burst;
    bit          s_acc, b_acc, b_pending;
    int          b_index, done_count, drop_err;
    bit          aw_wait, w_wait;
    logic [15:0] cur_waddr;
    logic [31:0] mem [0:16383];
    logic [15:0] aw_addr_q [$];
    logic [7:0]  aw_len_q [$];
    logic [31:0] w_data_q [$];
    logic [3:0]  w_strb_q [$];
    bit          w_last_q [$];

    function automatic bit go();
        return $urandom_range(99) >= stall_pct;
    endfunction

    // Drive slave/source inputs on the falling edge, observe handshakes
    // 1 ns before the rising edge that completes them.
    initial begin
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!(s_tvalid && !s_acc)) s_tvalid = (src_idx < src_len) && go();
            s_tdata = src_data[src_idx[6:0]];
            s_tlast = (src_idx == tlast_at);
            s_acc = 1'b0;
            m_awready = go();
            m_wready  = go();
            if (!(m_bvalid && !b_acc)) begin
                m_bvalid = b_pending && go();
                m_bresp  = (b_index == err_burst) ? 2'b10 : 2'b00;
            end
            b_acc = 1'b0;
            #4;
            if (aw_wait && !m_awvalid) drop_err++;
            if (w_wait && !m_wvalid) drop_err++;
            aw_wait = m_awvalid && !m_awready;
            w_wait  = m_wvalid && !m_wready;
            if (m_awvalid && m_awready) begin
                aw_addr_q.push_back(m_awaddr);
                aw_len_q.push_back(m_awlen);
                cur_waddr = m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                w_data_q.push_back(m_wdata);
                w_strb_q.push_back(m_wstrb);
                w_last_q.push_back(m_wlast);
                if (m_wstrb == 4'hF) mem[cur_waddr[15:2]] = m_wdata;
                cur_waddr = cur_waddr + 16'd4;
                if (m_wlast) b_pending = 1'b1;
            end
            if (s_tvalid && s_tready) begin
                src_idx++;
                s_acc = 1'b1;
            end
            if (m_bvalid && m_bready) begin
                b_pending = 1'b0;
                b_acc = 1'b1;
                b_index++;
            end
            if (done) done_count++;
        end
    end

    task automatic clear_logs(input int len, input int tl, input int stall, input int eb);
        aw_addr_q.delete(); aw_len_q.delete();
        w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        for (int i = 0; i < 128; i++) src_data[i] = 32'hA500_0000 + 32'(i * 3);
        src_len = len; src_idx = 0; tlast_at = tl;
        stall_pct = stall; err_burst = eb;
        s_acc = 1'b1; b_acc = 1'b1; b_pending = 1'b0;
        b_index = 0; done_count = 0; drop_err = 0;
        aw_wait = 1'b0; w_wait = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] addr, input logic [15:0] len);
        @(negedge clk);
        base_addr = addr; len_beats = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (done_count == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_count == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, limit);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; len_beats = '0;
        clear_logs(0, -1, 0, -1);
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, short_pkt, beats_written, s_tready, m_awvalid,
             m_awaddr, m_awlen, m_wvalid, m_wlast, m_wstrb, m_bready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b awvalid=%b wvalid=%b bready=%b beats=%0d expected all 0",
                     busy, done, m_awvalid, m_wvalid, m_bready, beats_written);
        end
        checks++;
        if ({m_awsize, m_awburst} !== {3'd2, 2'b01}) begin
            errors++;
            $display("FAIL reset_consts: awsize=%0d awburst=%b expected 2 01", m_awsize, m_awburst);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] exp_addr [3];
        logic [7:0]  exp_len [3];
        int nl;
        exp_addr = '{16'h0100, 16'h0140, 16'h0180};
        exp_len  = '{8'd15, 8'd15, 8'd7};
        clear_logs(40, 39, 0, -1);
        do_start(16'h0100, 16'd40);
        wait_done("basic", 500);
        checks++;
        if (aw_addr_q.size() != 3) begin
            errors++;
            $display("FAIL basic_aw_count: got %0d expected 3", aw_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] !== exp_len[i]) begin
                    errors++;
                    $display("FAIL basic_aw%0d: got addr=%h len=%0d expected addr=%h len=%0d",
                             i, aw_addr_q[i], aw_len_q[i], exp_addr[i], exp_len[i]);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (mem[(16'h0100 >> 2) + i] !== src_data[i]) begin
                errors++;
                $display("FAIL basic_mem%0d: got %h expected %h", i, mem[(16'h0100 >> 2) + i], src_data[i]);
            end
        end
        nl = 0;
        foreach (w_last_q[i]) if (w_last_q[i]) nl++;
        checks++;
        if (w_data_q.size() != 40 || nl != 3) begin
            errors++;
            $display("FAIL basic_wbeats: got beats=%0d wlasts=%0d expected 40 3", w_data_q.size(), nl);
        end
        checks++;
        if (beats_written !== 16'd40 || busy !== 1'b0 || err !== 1'b0 || short_pkt !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got beats=%0d busy=%b err=%b short=%b expected 40 0 0 0",
                     beats_written, busy, err, short_pkt);
        end
    endtask

    task automatic test_zero_len();
        clear_logs(0, -1, 0, -1);
        do_start(16'h0200, 16'd0);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done_cycle: got busy=%b done=%b expected 1 1", busy, done);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got busy=%b done=%b expected 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (aw_addr_q.size() != 0 || w_data_q.size() != 0 || done_count != 1 || beats_written !== 16'd0) begin
            errors++;
            $display("FAIL zero_traffic: got aw=%0d w=%0d dones=%0d beats=%0d expected 0 0 1 0",
                     aw_addr_q.size(), w_data_q.size(), done_count, beats_written);
        end
    endtask

    task automatic test_short_pkt();
        logic [3:0] exp_strb;
        logic [31:0] exp_data;
        clear_logs(5, 4, 0, -1);
        do_start(16'h0300, 16'd16);
        wait_done("short", 300);
        checks++;
        if (w_data_q.size() != 16 || aw_addr_q.size() != 1) begin
            errors++;
            $display("FAIL short_counts: got wbeats=%0d aws=%0d expected 16 1", w_data_q.size(), aw_addr_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp_strb = (i < 5) ? 4'hF : 4'h0;
                exp_data = (i < 5) ? src_data[i] : 32'h0;
                checks++;
                if (w_strb_q[i] !== exp_strb || w_data_q[i] !== exp_data || w_last_q[i] !== (i == 15)) begin
                    errors++;
                    $display("FAIL short_beat%0d: got strb=%h data=%h last=%b expected %h %h %b",
                             i, w_strb_q[i], w_data_q[i], w_last_q[i], exp_strb, exp_data, i == 15);
                end
            end
        end
        checks++;
        if (short_pkt !== 1'b1 || beats_written !== 16'd5 || err !== 1'b0) begin
            errors++;
            $display("FAIL short_status: got short=%b beats=%0d err=%b expected 1 5 0", short_pkt, beats_written, err);
        end
    endtask

    task automatic test_stalls();
        int bad = 0;
        clear_logs(100, 99, 35, -1);
        do_start(16'h0400, 16'd100);
        wait_done("stall", 3000);
        for (int i = 0; i < 100; i++) if (mem[(16'h0400 >> 2) + i] !== src_data[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_mem: got %0d wrong words expected 0", bad);
        end
        checks++;
        if (mem[(16'h0400 >> 2) + 100] !== 32'h0 || aw_addr_q.size() != 7) begin
            errors++;
            $display("FAIL stall_extent: got word100=%h aws=%0d expected 0 7", mem[(16'h0400 >> 2) + 100], aw_addr_q.size());
        end
        checks++;
        if (drop_err != 0) begin
            errors++;
            $display("FAIL stall_valid_drop: got %0d drops expected 0", drop_err);
        end
        checks++;
        if (beats_written !== 16'd100 || short_pkt !== 1'b0) begin
            errors++;
            $display("FAIL stall_status: got beats=%0d short=%b expected 100 0", beats_written, short_pkt);
        end
    endtask

    task automatic test_bresp_err();
        clear_logs(48, 47, 0, 1);
        do_start(16'h0800, 16'd48);
        wait_done("berr", 500);
        checks++;
        if (err !== 1'b1 || aw_addr_q.size() != 3 || b_index != 3 || beats_written !== 16'd48) begin
            errors++;
            $display("FAIL berr_status: got err=%b aws=%0d bs=%0d beats=%0d expected 1 3 3 48",
                     err, aw_addr_q.size(), b_index, beats_written);
        end
        clear_logs(4, 3, 0, -1);
        do_start(16'h0900, 16'd4);
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL berr_clear_on_start: got err=%b busy=%b expected 0 1", err, busy);
        end
        wait_done("berr2", 200);
        checks++;
        if (err !== 1'b0 || mem[(16'h0900 >> 2) + 3] !== src_data[3]) begin
            errors++;
            $display("FAIL berr_next: got err=%b word3=%h expected 0 %h", err, mem[(16'h0900 >> 2) + 3], src_data[3]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_logs(40, -1, 0, -1);
        do_start(16'h0200, 16'd40);
        forever begin
            @(negedge clk); #2;
            n++;
            if ((aw_addr_q.size() == 2 && m_wvalid) || n > 200) break;
        end
        checks++;
        if (n > 200) begin
            errors++;
            $display("FAIL midrst_reach_w2: never reached burst 2 W phase");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, short_pkt, beats_written, s_tready, m_awvalid,
             m_wvalid, m_wlast, m_wstrb, m_bready} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b awvalid=%b wvalid=%b tready=%b beats=%0d expected all 0",
                     busy, m_awvalid, m_wvalid, s_tready, beats_written);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_logs(4, 3, 0, -1);
        do_start(16'h0300, 16'd4);
        wait_done("midrst", 200);
        checks++;
        if (aw_addr_q.size() != 1 || w_data_q.size() != 4 || beats_written !== 16'd4) begin
            errors++;
            $display("FAIL midrst_fresh: got aws=%0d wbeats=%0d beats=%0d expected 1 4 4",
                     aw_addr_q.size(), w_data_q.size(), beats_written);
        end else begin
            checks++;
            if (aw_addr_q[0] !== 16'h0300 || aw_len_q[0] !== 8'd3 || mem[(16'h0300 >> 2)] !== src_data[0]) begin
                errors++;
                $display("FAIL midrst_aw: got addr=%h len=%0d word0=%h expected 0300 3 %h",
                         aw_addr_q[0], aw_len_q[0], mem[(16'h0300 >> 2)], src_data[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_short_pkt();
        test_stalls();
        test_bresp_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
